// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, issue-unit state type and decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return {16'h0000, imm};
            default:                  return {{16{imm[15]}}, imm};
        endcase
    endfunction

    function automatic logic op_writes_rt(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_SLTI, OP_SLTIU, OP_LW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two read ports, one write port, one debug read port.
// Register 0 is never written and always reads as zero.
module mips_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_ra,
    input  logic [4:0]  i_rb,
    output logic [31:0] o_rda,
    output logic [31:0] o_rdb,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data
);

    logic [31:0] r_regs [32];

    // Array clear on reset; single write port with r0 writes dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rda      = (i_ra == 5'd0)       ? '0 : r_regs[i_ra];
    assign o_rdb      = (i_rb == 5'd0)       ? '0 : r_regs[i_rb];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/mips_issue_unit.sv
// Multi-cycle MIPS issue unit: accepts an instruction, decodes it, drives the
// external combinational ALU, performs lw/sw handshakes and writes back.
module mips_issue_unit
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [5:0]        alu_opcode,
    output logic [5:0]        alu_funct,
    output logic [4:0]        alu_shamt,
    output logic [31:0]       alu_rs_content,
    output logic [31:0]       alu_rt_content,
    output logic [31:0]       alu_imme32,
    input  logic [31:0]       alu_result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic              err,
    output logic              br_taken,
    output logic [31:0]       br_offset,
    input  logic [4:0]        dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t             r_state;
    logic [31:0]        r_instr;
    logic [4:0]         r_dest;
    logic               r_wen;
    logic               r_illegal;
    logic [31:0]        r_result;
    logic [CNT_W-1:0]   r_cnt;

    logic [5:0]         w_op;
    logic [31:0]        w_rs_data;
    logic [31:0]        w_rt_data;
    logic               w_rf_we;
    logic               w_br_taken;
    logic               w_is_mem;

    assign w_op     = r_instr[31:26];
    assign w_rf_we  = (r_state == S_WB) && r_wen;
    assign w_is_mem = (alu_opcode == OP_LW) || (alu_opcode == OP_SW);

    assign w_br_taken = ((alu_opcode == OP_BEQ) && (alu_rs_content == alu_rt_content)) ||
                        ((alu_opcode == OP_BNE) && (alu_rs_content != alu_rt_content));

    mips_regfile u_regfile (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ra       (r_instr[25:21]),
        .i_rb       (r_instr[20:16]),
        .o_rda      (w_rs_data),
        .o_rdb      (w_rt_data),
        .i_we       (w_rf_we),
        .i_wa       (r_dest),
        .i_wd       (r_result),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Issue FSM with all handshake, ALU and status outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_instr        <= '0;
            r_dest         <= '0;
            r_wen          <= 1'b0;
            r_illegal      <= 1'b0;
            r_result       <= '0;
            r_cnt          <= '0;
            instr_ready    <= 1'b1;
            alu_opcode     <= '0;
            alu_funct      <= '0;
            alu_shamt      <= '0;
            alu_rs_content <= '0;
            alu_rt_content <= '0;
            alu_imme32     <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            br_taken       <= 1'b0;
            br_offset      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr     <= instr;
                        instr_ready <= 1'b0;
                        r_state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_opcode     <= w_op;
                    alu_funct      <= r_instr[5:0];
                    alu_shamt      <= r_instr[10:6];
                    alu_rs_content <= w_rs_data;
                    alu_rt_content <= w_rt_data;
                    alu_imme32     <= ext_imm(w_op, r_instr[15:0]);
                    r_illegal      <= !op_is_legal(w_op);
                    if (w_op == OP_RTYPE) begin
                        r_dest <= r_instr[15:11];
                        r_wen  <= 1'b1;
                    end else begin
                        r_dest <= r_instr[20:16];
                        r_wen  <= op_writes_rt(w_op);
                    end
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result  <= alu_result;
                    br_offset <= alu_imme32 << 2;
                    br_taken  <= w_br_taken;
                    if (r_illegal) begin
                        r_wen   <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        r_state <= S_WB;
                    end else if (w_is_mem) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (alu_opcode == OP_SW);
                        mem_addr  <= alu_result[ADDR_W-1:0];
                        mem_wdata <= alu_rt_content;
                        r_cnt     <= '0;
                        r_state   <= S_MEM;
                    end else begin
                        done    <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            r_result <= mem_rdata;
                        end
                        done    <= 1'b1;
                        r_state <= S_WB;
                    end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        r_wen   <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        r_state <= S_WB;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    done        <= 1'b0;
                    err         <= 1'b0;
                    br_taken    <= 1'b0;
                    instr_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_issue_unit.sv
// Randomized self-checking bench for mips_issue_unit with a behavioural
// reference model (register array, memory map, latency rules).
module tb_mips_issue_unit;
    import mips_pkg::*;

    localparam int unsigned MEM_TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_funct;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_rs_content;
    logic [31:0] alu_rt_content;
    logic [31:0] alu_imme32;
    logic [31:0] alu_result;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        done;
    logic        err;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [31:0] regs_m [32];
    logic [31:0] mem_m [logic [31:0]];

    logic [5:0] op_tab [15] = '{OP_RTYPE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
                                OP_LUI, OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE, OP_LW, OP_SW,
                                6'h3F, 6'h02};
    logic [5:0] fn_tab [13] = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
                                FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA};

    mips_issue_unit #(.MEM_TIMEOUT(MEM_TO), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .alu_opcode     (alu_opcode),
        .alu_funct      (alu_funct),
        .alu_shamt      (alu_shamt),
        .alu_rs_content (alu_rs_content),
        .alu_rt_content (alu_rt_content),
        .alu_imme32     (alu_imme32),
        .alu_result     (alu_result),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .done           (done),
        .err            (err),
        .br_taken       (br_taken),
        .br_offset      (br_offset),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: what the external ALU computes from its operands.
    function automatic logic [31:0] tb_alu(input logic [5:0] op, input logic [5:0] fn,
                                           input logic [4:0] sh, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_ADDU: return a + b;
                    FN_SUB, FN_SUBU: return a - b;
                    FN_AND:  return a & b;
                    FN_OR:   return a | b;
                    FN_XOR:  return a ^ b;
                    FN_NOR:  return ~(a | b);
                    FN_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    FN_SLTU: return (a < b) ? 32'd1 : 32'd0;
                    FN_SLL:  return b << sh;
                    FN_SRL:  return b >> sh;
                    FN_SRA:  return $unsigned($signed(b) >>> sh);
                    default: return 32'd0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: return a + imm;
            OP_ANDI:  return a & imm;
            OP_ORI:   return a | imm;
            OP_XORI:  return a ^ imm;
            OP_LUI:   return imm << 16;
            OP_SLTI:  return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: return (a < imm) ? 32'd1 : 32'd0;
            OP_BEQ, OP_BNE: return a - b;
            default:  return 32'd0;
        endcase
    endfunction

    always_comb alu_result = tb_alu(alu_opcode, alu_funct, alu_shamt,
                                    alu_rs_content, alu_rt_content, alu_imme32);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_list(input logic [5:0] op);
        for (int i = 0; i < 13; i++) begin
            if (op_tab[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic dbg_chk(input logic [4:0] r, input string tag);
        dbg_addr = r;
        #1;
        chk(tag, dbg_data, regs_m[r]);
    endtask

    // Issue one instruction; ack_k = MEM cycle on which mem_ack is given (0 = never).
    task automatic run_instr(input logic [31:0] ins, input int unsigned ack_k);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, dest;
        logic [31:0] imm, a, b, addr, res, d;
        logic        legal, is_mem, tmo, has_wr, taken, exp_err, got;
        int unsigned lat, c, m;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        legal  = in_list(op);
        imm    = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ?
                 {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        a      = regs_m[rs];
        b      = regs_m[rt];
        is_mem = legal && (op == OP_LW || op == OP_SW);
        tmo    = is_mem && (ack_k == 0 || ack_k > MEM_TO);
        exp_err = !legal || tmo;
        lat    = !is_mem ? 3 : (tmo ? 3 + MEM_TO : 3 + ack_k);
        addr   = a + imm;
        d      = 32'd0;
        if (op == OP_LW) begin
            if (mem_m.exists(addr)) d = mem_m[addr];
            else begin d = $urandom; mem_m[addr] = d; end
        end
        res    = (op == OP_LW) ? d : tb_alu(op, ins[5:0], ins[10:6], a, b, imm);
        has_wr = legal && (op == OP_RTYPE || op == OP_ADDI || op == OP_ADDIU ||
                 op == OP_ANDI || op == OP_ORI || op == OP_XORI || op == OP_LUI ||
                 op == OP_SLTI || op == OP_SLTIU || op == OP_LW) && !tmo;
        dest   = (op == OP_RTYPE) ? rd : rt;
        taken  = (op == OP_BEQ && a == b) || (op == OP_BNE && a != b);

        @(negedge clk);
        chk("instr_ready_idle", {31'd0, instr_ready}, 32'd1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;

        c = 0; m = 0; got = 1'b0;
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            mem_ack = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (c == 2) begin
                    chk("alu_opcode", {26'd0, alu_opcode}, {26'd0, op});
                    chk("alu_funct", {26'd0, alu_funct}, {26'd0, ins[5:0]});
                    chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, ins[10:6]});
                    chk("alu_rs_content", alu_rs_content, a);
                    chk("alu_rt_content", alu_rt_content, b);
                    if (legal) chk("alu_imme32", alu_imme32, imm);
                end
                if (mem_req) begin
                    m++;
                    if (m == 1) begin
                        chk("mem_we", {31'd0, mem_we}, {31'd0, op == OP_SW});
                        chk("mem_addr", mem_addr, addr);
                        if (op == OP_SW) chk("mem_wdata", mem_wdata, b);
                    end
                    if (m == ack_k) begin
                        mem_ack = 1'b1;
                        mem_rdata = (op == OP_LW) ? d : $urandom;
                    end
                end
            end
        end
        mem_ack = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", c, lat);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("br_taken", {31'd0, br_taken}, {31'd0, taken});
        if (!exp_err) chk("br_offset", br_offset, imm << 2);
        chk("mem_req_wb", {31'd0, mem_req}, 32'd0);

        if (has_wr && dest != 5'd0) regs_m[dest] = res;
        if (op == OP_SW && !tmo) mem_m[addr] = b;

        @(posedge clk);
        #1;
        dbg_chk(dest, "dbg_dest");
        dbg_chk(5'($urandom_range(0, 31)), "dbg_rand");
    endtask

    task automatic reset_in_mem();
        int unsigned w;
        logic        seen;
        @(negedge clk);
        instr = 32'h8C060010;   // lw $6,16($0), never acked
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        w = 0;
        while (!mem_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("mem_req_before_rst", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || mem_req) seen = 1'b1;
        end
        chk("no_done_after_rst", {31'd0, seen}, 32'd0);
        dbg_chk(5'd6, "dbg_r6_after_rst");
        dbg_chk(5'd3, "dbg_r3_after_rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        int unsigned k;

        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 32; i++) dbg_chk(5'(i), "reset_reg");

        // Directed sequence
        run_instr(32'h2001FFFB, 0);   // addi $1,$0,-5
        run_instr(32'h34028000, 0);   // ori  $2,$0,0x8000
        run_instr(32'h00221820, 0);   // add  $3,$1,$2
        chk("reg3_value", regs_m[3], 32'h00007FFB);
        run_instr(32'hAC030004, 2);   // sw   $3,4($0)
        run_instr(32'h8C040004, 3);   // lw   $4,4($0)
        run_instr(32'h8C050008, 0);   // lw   $5,8($0) timeout
        run_instr(32'h10640002, 0);   // beq  $3,$4,+2
        run_instr(32'h14640002, 0);   // bne  $3,$4,+2
        run_instr(32'hFC010001, 0);   // illegal opcode 0x3F

        // Randomized instructions over a small register window
        for (int n = 0; n < 80; n++) begin
            op = op_tab[$urandom_range(0, 14)];
            k  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            if (op == OP_RTYPE) begin
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                       fn_tab[$urandom_range(0, 12)]};
            end else if (op == OP_LW || op == OP_SW) begin
                ins = {op, 5'd0, 5'($urandom_range(0, 7)), 16'($urandom_range(0, 15) * 4)};
            end else begin
                ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            end
            run_instr(ins, k);
        end

        reset_in_mem();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
